// File: rtl/block_load_writer.sv
// rtl/block_load_writer.sv - LDM write-back sequencer; base-register update enabled by BLOCK_LOAD_WBACK_EN
module block_load_writer #(
    parameter int NUM_REGS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] reg_list,
    input  logic [31:0] base_addr,
    input  logic [3:0]  base_reg,
    input  logic        up,
    input  logic        wback,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_wb,
    output logic        writeBackEn,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
`ifdef BLOCK_LOAD_WBACK_EN
        S_WB_BASE = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] list_q, list_d;
    logic [31:0]         addr_q, addr_d;
    logic [3:0]          dest_q, dest_d;
    logic [31:0]         result_q, result_d;
    logic                wben_q, wben_d;
`ifdef BLOCK_LOAD_WBACK_EN
    logic [31:0]         fbase_q, fbase_d;
    logic [3:0]          breg_q, breg_d;
    logic                do_wb_q, do_wb_d;
    logic                base_in_list;
`endif

    logic [NUM_REGS-1:0] start_list;
    logic [4:0]          start_cnt;
    logic [31:0]         span;
    logic [3:0]          cur_idx;
    logic [NUM_REGS-1:0] list_rest;

    // Bits at and above NUM_REGS (the PC) never take part in the transfer.
    logic unused_inputs;
    assign unused_inputs = ^{reg_list, base_reg, wback};

    // Popcount of the incoming list and the 4*N byte span it covers.
    always_comb begin
        start_list = reg_list[NUM_REGS-1:0];
        start_cnt  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            start_cnt = start_cnt + {4'd0, start_list[i]};
        end
        span = {25'd0, start_cnt, 2'b00};
    end

    // Lowest pending register is always the next one loaded; list_rest drops it.
    always_comb begin
        cur_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (list_q[i]) cur_idx = 4'(i);
        end
        list_rest = list_q & (list_q - {{(NUM_REGS-1){1'b0}}, 1'b1});
    end

`ifdef BLOCK_LOAD_WBACK_EN
    // A listed base register receives loaded data, which beats the writeback.
    always_comb begin
        base_in_list = (int'(base_reg) < NUM_REGS) && reg_list[base_reg];
    end
`endif

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        list_d   = list_q;
        addr_d   = addr_q;
        dest_d   = dest_q;
        result_d = result_q;
        wben_d   = 1'b0;
`ifdef BLOCK_LOAD_WBACK_EN
        fbase_d  = fbase_q;
        breg_d   = breg_q;
        do_wb_d  = do_wb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef BLOCK_LOAD_WBACK_EN
                    fbase_d = up ? (base_addr + span) : (base_addr - span);
                    breg_d  = base_reg;
                    do_wb_d = wback && !base_in_list;
`endif
                    list_d = start_list;
                    if (start_cnt != 5'd0) begin
                        addr_d  = up ? base_addr : (base_addr - span);
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_valid) begin
                    dest_d   = cur_idx;
                    result_d = mem_rdata;
                    wben_d   = 1'b1;
                    list_d   = list_rest;
                    if (|list_rest) begin
                        addr_d  = addr_q + 32'd4;
                        state_d = S_REQ;
`ifdef BLOCK_LOAD_WBACK_EN
                    end else if (do_wb_q) begin
                        state_d = S_WB_BASE;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
`ifdef BLOCK_LOAD_WBACK_EN
            S_WB_BASE: begin
                dest_d   = breg_q;
                result_d = fbase_q;
                wben_d   = 1'b1;
                state_d  = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            list_q   <= '0;
            addr_q   <= '0;
            dest_q   <= '0;
            result_q <= '0;
            wben_q   <= 1'b0;
`ifdef BLOCK_LOAD_WBACK_EN
            fbase_q  <= '0;
            breg_q   <= '0;
            do_wb_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            list_q   <= list_d;
            addr_q   <= addr_d;
            dest_q   <= dest_d;
            result_q <= result_d;
            wben_q   <= wben_d;
`ifdef BLOCK_LOAD_WBACK_EN
            fbase_q  <= fbase_d;
            breg_q   <= breg_d;
            do_wb_q  <= do_wb_d;
`endif
        end
    end

    assign mem_rd_en   = (state_q == S_REQ);
    assign mem_addr    = addr_q;
    assign Dest_wb     = dest_q;
    assign Result_wb   = result_q;
    assign writeBackEn = wben_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_block_load_writer.sv
// tb/tb_block_load_writer.sv - randomized self-checking bench for block_load_writer
module tb_block_load_writer;

    localparam int NREGS = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] reg_list = '0;
    logic [31:0] base_addr = '0;
    logic [3:0]  base_reg = '0;
    logic        up = 1'b0;
    logic        wback = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_wb;
    logic        writeBackEn;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    block_load_writer #(.NUM_REGS(NREGS)) dut (
        .clk(clk), .rst(rst), .start(start), .reg_list(reg_list),
        .base_addr(base_addr), .base_reg(base_reg), .up(up), .wback(wback),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .Dest_wb(Dest_wb), .Result_wb(Result_wb),
        .writeBackEn(writeBackEn), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One complete LDM transfer against a list-level model: expected reads are
    // consecutive words from the lowest address, expected writes are the listed
    // registers in ascending order followed by the optional base write.
    task automatic run_xfer(input logic [15:0] list, input logic [31:0] base,
                            input logic [3:0] breg, input bit up_v, input bit wb_v,
                            input int dmin, input int dmax, input bit noisy,
                            input int exp_cycles);
        logic [31:0] exp_addr[16];
        logic [31:0] rdata[16];
        logic [3:0]  exp_dest[17];
        logic [31:0] exp_data[17];
        logic [31:0] first;
        int n, nw, rd_i, wr_i, cyc, cnt, pidx;
        bit pend, seen_done, busy_ok;
        n = 0;
        for (int r = 0; r < NREGS; r++) begin
            if (list[r]) begin
                rdata[n]    = $urandom;
                exp_dest[n] = 4'(r);
                exp_data[n] = rdata[n];
                n++;
            end
        end
        first = up_v ? base : base - 32'(4 * n);
        for (int k = 0; k < n; k++) exp_addr[k] = first + 32'(4 * k);
        nw = n;
`ifdef BLOCK_LOAD_WBACK_EN
        if (n > 0 && wb_v && !(int'(breg) < NREGS && list[breg])) begin
            exp_dest[nw] = breg;
            exp_data[nw] = up_v ? base + 32'(4 * n) : base - 32'(4 * n);
            nw++;
        end
`endif
        reg_list = list; base_addr = base; base_reg = breg; up = up_v; wback = wb_v;
        start = 1'b1; mem_valid = 1'b0;
        rd_i = 0; wr_i = 0; cyc = 0; cnt = 0; pidx = 0;
        pend = 0; seen_done = 0; busy_ok = 1;
        while (!seen_done && cyc < 300) begin
            @(posedge clk); #1; cyc++;
            start = noisy ? ($urandom_range(3, 0) == 0) : 1'b0;
            if (noisy) begin
                reg_list = 16'($urandom); base_addr = $urandom; base_reg = 4'($urandom);
                up = 1'($urandom); wback = 1'($urandom);
            end
            mem_valid = 1'b0;
            mem_rdata = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = rdata[pidx];
                    pend = 0;
                end
            end else if (noisy && $urandom_range(2, 0) == 0) begin
                mem_valid = 1'b1;
            end
            if (mem_rd_en) begin
                if (rd_i < n) begin
                    check("rd_addr", mem_addr, exp_addr[rd_i]);
                    pidx = rd_i;
                end else begin
                    check("rd_extra", rd_i, n);
                    pidx = 0;
                end
                pend = 1;
                cnt = $urandom_range(dmax, dmin);
                rd_i++;
            end
            if (writeBackEn) begin
                if (wr_i < nw) begin
                    check("wb_dest", 32'(Dest_wb), 32'(exp_dest[wr_i]));
                    check("wb_data", Result_wb, exp_data[wr_i]);
                end else begin
                    check("wb_extra", wr_i, nw);
                end
                wr_i++;
            end
            if (done) begin
                seen_done = 1;
                start = 1'b0;
                mem_valid = 1'b0;
                check("done_with_last_wb", 32'(writeBackEn), 32'(nw > 0));
                if (exp_cycles >= 0) check("done_cycle", cyc, exp_cycles);
            end else if (!busy) begin
                busy_ok = 0;
            end
        end
        check("done_seen", 32'(seen_done), 32'd1);
        check("read_count", rd_i, n);
        check("write_count", wr_i, nw);
        check("busy_held", 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_wait();
        int guard;
        reg_list = 16'h00F0; base_addr = 32'h0000_4000; base_reg = 4'd2;
        up = 1'b1; wback = 1'b1; start = 1'b1;
        guard = 0;
        @(posedge clk); #1; start = 1'b0;
        while (!mem_rd_en && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check("rst_reached_req", 32'(mem_rd_en), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_dest", 32'(Dest_wb), 32'd0);
        check("rst_result", Result_wb, 32'd0);
        check("rst_wben", 32'(writeBackEn), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        mem_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_no_write", 32'(writeBackEn), 32'd0);
        mem_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_still_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_wben", 32'(writeBackEn), 32'd0);
        check("reset_rd_en", 32'(mem_rd_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dest_result", {Dest_wb, Result_wb[27:0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef BLOCK_LOAD_WBACK_EN
        run_xfer(16'h0006, 32'h0000_0100, 4'd0, 1'b1, 1'b1, 1, 1, 1'b0, 6);
`else
        run_xfer(16'h0006, 32'h0000_0100, 4'd0, 1'b1, 1'b1, 1, 1, 1'b0, 5);
`endif
        run_xfer(16'h0009, 32'h0000_0200, 4'd3, 1'b0, 1'b1, 1, 1, 1'b0, 5);
        run_xfer(16'h8000, 32'h0000_0300, 4'd1, 1'b1, 1'b1, 1, 1, 1'b0, 1);
        run_xfer(16'h0000, 32'h0000_0300, 4'd1, 1'b0, 1'b0, 1, 1, 1'b0, 1);
        run_xfer(16'h0412, 32'h0000_1000, 4'd7, 1'b1, 1'b1, 5, 5, 1'b1, -1);
        run_xfer(16'h0003, 32'hFFFF_FFFC, 4'd5, 1'b1, 1'b1, 1, 1, 1'b0, -1);
        run_xfer(16'h7FFF, 32'h0000_0010, 4'd15, 1'b0, 1'b1, 1, 2, 1'b0, -1);

        reset_mid_wait();
        run_xfer(16'h0021, 32'h0000_0800, 4'd4, 1'b0, 1'b1, 1, 1, 1'b0, -1);

        for (int t = 0; t < 30; t++) begin
            logic [15:0] l;
            l = 16'($urandom);
            if (t % 2 == 0) l = l & 16'($urandom);
            run_xfer(l, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
                     1, $urandom_range(3, 1), 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
